// File: rtl/de3cd_unpacket.sv
// DE3CD frame unpacketizer: drains the ping-pong packet FIFOs frame by frame in
// prog_empty-gated bursts, re-emits payload words on an AXI4-Stream master with
// SOF (tuser) / EOF (tlast) marking, and discards the trailing fill words.
module de3cd_unpacket #(
  parameter int unsigned FRAME_WORDS = 9120,
  parameter int unsigned PAD_WORDS   = 17,
  parameter int unsigned BURST_LEN   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        region_indc,
  input  logic        region_valid,
  input  logic [63:0] fifo_1_rdata,
  input  logic        fifo_1_rdempty,
  input  logic        prog_1_empty,
  output logic        fifo_1_rden,
  input  logic [63:0] fifo_2_rdata,
  input  logic        fifo_2_rdempty,
  input  logic        prog_2_empty,
  output logic        fifo_2_rden,
  output logic [63:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic        frame_done,
  output logic        overrun,
  output logic        busy
);

  localparam int unsigned BurstW = $clog2(BURST_LEN) + 1;
  localparam int unsigned PadW   = $clog2(PAD_WORDS) + 1;

  localparam logic [16:0]       FrameLen   = 17'(FRAME_WORDS);
  localparam logic [16:0]       BurstLen17 = 17'(BURST_LEN);
  localparam logic [BurstW-1:0] BurstLenB  = BurstW'(BURST_LEN);
  localparam logic [BurstW-1:0] BurstOne   = BurstW'(1);
  localparam logic [PadW-1:0]   PadLen     = PadW'(PAD_WORDS);
  localparam logic [PadW-1:0]   PadOne     = PadW'(1);
  localparam logic [15:0]       LastIdx    = 16'(FRAME_WORDS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StGate,
    StBurst,
    StDrain,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic              pend_v_q, pend_v_d;
  logic              pend_sel_q, pend_sel_d;
  logic              cur_sel_q, cur_sel_d;
  logic              overrun_q, overrun_d;
  logic [15:0]       word_cnt_q, word_cnt_d;
  logic [BurstW-1:0] burst_cnt_q, burst_cnt_d;
  logic [PadW-1:0]   pad_cnt_q, pad_cnt_d;
  logic [63:0]       tdata_q, tdata_d;
  logic              tvalid_q, tvalid_d;
  logic              tlast_q, tlast_d;
  logic              tuser_q, tuser_d;

  logic [63:0] sel_rdata;
  logic        sel_rdempty;
  logic        sel_prog_empty;
  logic [16:0] rem;
  logic        rem_short;
  logic        pop_burst;
  logic        pop_drain;
  logic        pop;
  logic        consume;

  // Route the selected FIFO and decode the pop conditions for this cycle.
  always_comb begin
    sel_rdata      = cur_sel_q ? fifo_1_rdata   : fifo_2_rdata;
    sel_rdempty    = cur_sel_q ? fifo_1_rdempty : fifo_2_rdempty;
    sel_prog_empty = cur_sel_q ? prog_1_empty   : prog_2_empty;
    rem            = FrameLen - {1'b0, word_cnt_q};
    rem_short      = (rem < BurstLen17);
    // A payload pop needs room in the output register: empty or being accepted now.
    pop_burst      = (state_q == StBurst) && !sel_rdempty && (!tvalid_q || m_axis_tready);
    // Fill words are thrown away, so the sink is irrelevant here.
    pop_drain      = (state_q == StDrain) && !sel_rdempty;
    pop            = pop_burst || pop_drain;
    consume        = (state_q == StIdle) && pend_v_q;
  end

  // Next-state logic: notification slot, frame FSM, counters and output register.
  always_comb begin
    state_d     = state_q;
    pend_v_d    = pend_v_q;
    pend_sel_d  = pend_sel_q;
    cur_sel_d   = cur_sel_q;
    overrun_d   = overrun_q;
    word_cnt_d  = word_cnt_q;
    burst_cnt_d = burst_cnt_q;
    pad_cnt_d   = pad_cnt_q;
    tdata_d     = tdata_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    tuser_d     = tuser_q;

    // Consuming the slot and refilling it in the same cycle is legal, so the
    // clear comes first and a new notification may overwrite it.
    if (consume) begin
      pend_v_d = 1'b0;
    end
    if (region_valid) begin
      if (!pend_v_q || consume) begin
        pend_v_d   = 1'b1;
        pend_sel_d = region_indc;
      end else begin
        overrun_d = 1'b1;
      end
    end

    case (state_q)
      StIdle: begin
        if (pend_v_q) begin
          cur_sel_d  = pend_sel_q;
          word_cnt_d = '0;
          state_d    = StGate;
        end
      end
      StGate: begin
        // The tail of a frame is shorter than the threshold, so prog_empty would
        // never drop; any data at all is enough to start the short burst.
        if (!sel_prog_empty || (rem_short && !sel_rdempty)) begin
          burst_cnt_d = rem_short ? BurstW'(rem) : BurstLenB;
          state_d     = StBurst;
        end
      end
      StBurst: begin
        if (pop_burst) begin
          word_cnt_d  = word_cnt_q + 16'd1;
          burst_cnt_d = burst_cnt_q - BurstOne;
          if (burst_cnt_q == BurstOne) begin
            if (({1'b0, word_cnt_q} + 17'd1) == FrameLen) begin
              pad_cnt_d = '0;
              state_d   = (PAD_WORDS == 0) ? StDone : StDrain;
            end else begin
              state_d = StGate;
            end
          end
        end
      end
      StDrain: begin
        if (pop_drain) begin
          pad_cnt_d = pad_cnt_q + PadOne;
          if ((pad_cnt_q + PadOne) == PadLen) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Output register: a load always wins over a plain handshake.
    if (pop_burst) begin
      tdata_d  = sel_rdata;
      tvalid_d = 1'b1;
      tuser_d  = (word_cnt_q == 16'd0);
      tlast_d  = (word_cnt_q == LastIdx);
    end else if (tvalid_q && m_axis_tready) begin
      tvalid_d = 1'b0;
      tuser_d  = 1'b0;
      tlast_d  = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      pend_v_q    <= 1'b0;
      pend_sel_q  <= 1'b0;
      cur_sel_q   <= 1'b0;
      overrun_q   <= 1'b0;
      word_cnt_q  <= '0;
      burst_cnt_q <= '0;
      pad_cnt_q   <= '0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tuser_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_v_q    <= pend_v_d;
      pend_sel_q  <= pend_sel_d;
      cur_sel_q   <= cur_sel_d;
      overrun_q   <= overrun_d;
      word_cnt_q  <= word_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      pad_cnt_q   <= pad_cnt_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      tuser_q     <= tuser_d;
    end
  end

  // Outputs: pops are combinational, everything else comes straight from flops.
  always_comb begin
    fifo_1_rden   = pop && cur_sel_q;
    fifo_2_rden   = pop && !cur_sel_q;
    m_axis_tdata  = tdata_q;
    m_axis_tvalid = tvalid_q;
    m_axis_tlast  = tlast_q;
    m_axis_tuser  = tuser_q;
    frame_done    = (state_q == StDone);
    overrun       = overrun_q;
    busy          = (state_q != StIdle);
  end

endmodule

// File: tb/tb_de3cd_unpacket.sv
// Bench for de3cd_unpacket: queue-modelled FWFT FIFOs, randomized frame data and
// sink backpressure, scoreboard of expected beats checked by a separate monitor.
module tb_de3cd_unpacket;

  localparam int unsigned FW = 20;
  localparam int unsigned PW = 17;
  localparam int unsigned BL = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        region_indc = 1'b0;
  logic        region_valid = 1'b0;
  logic [63:0] fifo_1_rdata, fifo_2_rdata;
  logic        fifo_1_rdempty, fifo_2_rdempty;
  logic        prog_1_empty, prog_2_empty;
  logic        fifo_1_rden, fifo_2_rden;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tlast, m_axis_tuser;
  logic        frame_done, overrun, busy;

  always #5 clk = ~clk;

  de3cd_unpacket #(
    .FRAME_WORDS(FW),
    .PAD_WORDS  (PW),
    .BURST_LEN  (BL)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .region_indc   (region_indc),
    .region_valid  (region_valid),
    .fifo_1_rdata  (fifo_1_rdata),
    .fifo_1_rdempty(fifo_1_rdempty),
    .prog_1_empty  (prog_1_empty),
    .fifo_1_rden   (fifo_1_rden),
    .fifo_2_rdata  (fifo_2_rdata),
    .fifo_2_rdempty(fifo_2_rdempty),
    .prog_2_empty  (prog_2_empty),
    .fifo_2_rden   (fifo_2_rden),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .frame_done    (frame_done),
    .overrun       (overrun),
    .busy          (busy)
  );

  typedef struct packed {
    logic [63:0] d;
    logic        u;
    logic        l;
  } beat_t;

  beat_t       exp_q[$];
  logic [63:0] f1[$], f2[$], feed1[$], feed2[$];
  int checks = 0;
  int failures = 0;
  int pops1 = 0, pops2 = 0;
  int done_cnt = 0, beat_cnt = 0;
  int feed_div = 1;
  int cyc = 0;
  bit bp_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp_v);
    end
  endtask

  task automatic drive_fifos();
    fifo_1_rdata   = (f1.size() > 0) ? f1[0] : 64'd0;
    fifo_1_rdempty = (f1.size() == 0);
    prog_1_empty   = (f1.size() < BL);
    fifo_2_rdata   = (f2.size() > 0) ? f2[0] : 64'd0;
    fifo_2_rdempty = (f2.size() == 0);
    prog_2_empty   = (f2.size() < BL);
  endtask

  // A burst may only start with a threshold's worth of data, except for the frame
  // tail; every burst after the first must follow a pop-free cycle.
  task automatic gate_chk(input bit p, input int pops, input int size, input bit lastp,
                          input string nm);
    int pos;
    pos = pops % (FW + PW);
    if (p && (pos < FW) && (pos % BL == 0)) begin
      chk({nm, "_threshold"}, 64'((size >= BL) || ((FW - pos) < BL)), 64'd1);
      if (pos > 0) chk({nm, "_bubble"}, 64'(lastp), 64'd0);
    end
  endtask

  // FIFO model: sample pops at negedge, apply them just after the next posedge.
  initial begin
    bit p1, p2, l1, l2;
    l1 = 1'b0;
    l2 = 1'b0;
    drive_fifos();
    forever begin
      @(negedge clk);
      p1 = rst_n && fifo_1_rden;
      p2 = rst_n && fifo_2_rden;
      if (rst_n) begin
        chk("rden1_while_empty", 64'(fifo_1_rden & fifo_1_rdempty), 64'd0);
        chk("rden2_while_empty", 64'(fifo_2_rden & fifo_2_rdempty), 64'd0);
        chk("rden_both", 64'(fifo_1_rden & fifo_2_rden), 64'd0);
        gate_chk(p1, pops1, f1.size(), l1, "gate1");
        gate_chk(p2, pops2, f2.size(), l2, "gate2");
      end
      @(posedge clk);
      #1;
      cyc++;
      if (p1 && f1.size() > 0) begin
        f1.delete(0);
        pops1++;
      end
      if (p2 && f2.size() > 0) begin
        f2.delete(0);
        pops2++;
      end
      l1 = p1;
      l2 = p2;
      if (cyc % feed_div == 0) begin
        if (feed1.size() > 0) f1.push_back(feed1.pop_front());
        if (feed2.size() > 0) f2.push_back(feed2.pop_front());
      end
      drive_fifos();
    end
  end

  // Sink: random backpressure with ~30% low when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_axis_tready = bp_en ? ($urandom_range(0, 99) >= 30) : 1'b1;
    end
  end

  // Monitor: compares accepted beats against the scoreboard and checks stall stability.
  initial begin
    beat_t e, prev;
    bit stall, done_prev;
    stall = 1'b0;
    done_prev = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 1'b0;
        done_prev = 1'b0;
        continue;
      end
      if (stall) begin
        chk("hold_valid", 64'(m_axis_tvalid), 64'd1);
        chk("hold_data", m_axis_tdata, prev.d);
        chk("hold_flags", 64'({m_axis_tuser, m_axis_tlast}), 64'({prev.u, prev.l}));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        beat_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual=%0h expected=none", m_axis_tdata);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", m_axis_tdata, e.d);
          chk("beat_flags", 64'({m_axis_tuser, m_axis_tlast}), 64'({e.u, e.l}));
        end
      end
      stall = m_axis_tvalid && !m_axis_tready;
      prev.d = m_axis_tdata;
      prev.u = m_axis_tuser;
      prev.l = m_axis_tlast;
      if (done_prev) chk("idle_after_done", 64'(busy), 64'd0);
      if (frame_done) done_cnt++;
      done_prev = frame_done;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic notify(input bit sel);
    @(posedge clk);
    #1;
    region_valid = 1'b1;
    region_indc  = sel;
    @(posedge clk);
    #1;
    region_valid = 1'b0;
  endtask

  // One frame of payload plus fill; payload beats go to the scoreboard in load order.
  task automatic load_frame(input bit sel, input bit slow);
    logic [31:0] base;
    logic [63:0] w;
    beat_t bt;
    base = $urandom;
    for (int i = 0; i < int'(FW + PW); i++) begin
      w = {base, 32'(i)};
      if (sel) begin
        if (slow) feed1.push_back(w);
        else f1.push_back(w);
      end else begin
        if (slow) feed2.push_back(w);
        else f2.push_back(w);
      end
      if (i < int'(FW)) begin
        bt.d = w;
        bt.u = (i == 0);
        bt.l = (i == int'(FW) - 1);
        exp_q.push_back(bt);
      end
    end
    drive_fifos();
  endtask

  task automatic wait_done(input int target, input int limit, input string nm);
    int n;
    n = 0;
    while (done_cnt < target && n < limit) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk(nm, 64'(done_cnt), 64'(target));
  endtask

  task automatic check_reset_state(input string pfx);
    @(negedge clk);
    chk({pfx, "_tdata"}, m_axis_tdata, 64'd0);
    chk({pfx, "_tvalid"}, 64'(m_axis_tvalid), 64'd0);
    chk({pfx, "_tlast"}, 64'(m_axis_tlast), 64'd0);
    chk({pfx, "_tuser"}, 64'(m_axis_tuser), 64'd0);
    chk({pfx, "_rden1"}, 64'(fifo_1_rden), 64'd0);
    chk({pfx, "_rden2"}, 64'(fifo_2_rden), 64'd0);
    chk({pfx, "_frame_done"}, 64'(frame_done), 64'd0);
    chk({pfx, "_overrun"}, 64'(overrun), 64'd0);
    chk({pfx, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int p2s, b0, n;
    // Reset values.
    step(3);
    rst_n = 1'b1;
    check_reset_state("reset");

    // Single preloaded frame from fifo_1, sink always ready.
    p2s = pops2;
    load_frame(1'b1, 1'b0);
    notify(1'b1);
    wait_done(1, 500, "t1_done");
    step(5);
    chk("t1_scoreboard_empty", 64'(exp_q.size()), 64'd0);
    chk("t1_fifo1_pops", 64'(pops1), 64'(FW + PW));
    chk("t1_fifo2_untouched", 64'(pops2), 64'(p2s));
    chk("t1_overrun", 64'(overrun), 64'd0);

    // Slow producer into fifo_2: bursts gated by prog_empty, short tail burst.
    feed_div = 4;
    load_frame(1'b0, 1'b1);
    notify(1'b0);
    wait_done(2, 1000, "t2_done");
    step(5);
    feed_div = 1;
    chk("t2_scoreboard_empty", 64'(exp_q.size()), 64'd0);
    chk("t2_fifo2_pops", 64'(pops2), 64'(FW + PW));

    // Ping-pong with the second notification mid-frame, random backpressure.
    bp_en = 1'b1;
    load_frame(1'b1, 1'b0);
    load_frame(1'b0, 1'b0);
    notify(1'b1);
    step(8);
    notify(1'b0);
    wait_done(4, 2000, "t3_done");
    step(30);
    bp_en = 1'b0;
    step(3);
    chk("t3_scoreboard_empty", 64'(exp_q.size()), 64'd0);
    chk("t3_overrun", 64'(overrun), 64'd0);

    // Three notifications during one frame: the third is dropped, overrun sticks.
    load_frame(1'b1, 1'b0);
    load_frame(1'b0, 1'b0);
    notify(1'b1);
    step(6);
    notify(1'b0);
    step(2);
    notify(1'b1);
    chk("t4_overrun_set", 64'(overrun), 64'd1);
    wait_done(6, 2000, "t4_done");
    step(30);
    chk("t4_no_third_frame", 64'(done_cnt), 64'd6);
    chk("t4_idle", 64'(busy), 64'd0);
    chk("t4_overrun_sticky", 64'(overrun), 64'd1);
    chk("t4_scoreboard_empty", 64'(exp_q.size()), 64'd0);

    // Reset partway through a frame.
    load_frame(1'b1, 1'b0);
    b0 = beat_cnt;
    notify(1'b1);
    n = 0;
    while (beat_cnt < b0 + 10 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("t5_reached_word10", 64'(beat_cnt >= b0 + 10), 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    f1.delete();
    f2.delete();
    feed1.delete();
    feed2.delete();
    pops1 = 0;
    pops2 = 0;
    drive_fifos();
    check_reset_state("t5_after_reset");
    step(10);
    chk("t5_stays_idle", 64'(busy), 64'd0);
    chk("t5_no_done", 64'(done_cnt), 64'd6);

    // Recovery: a clean frame from fifo_2 after the reset.
    load_frame(1'b0, 1'b0);
    notify(1'b0);
    wait_done(7, 500, "t6_done");
    step(5);
    chk("t6_scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
